// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle W = N*K bit adder that streams N-bit slices, LSB
// first, through one addern slice adder. A carry register chains the slices.
// Optional feature macro: WIDE_ADD_SUB_EN adds a 'sub' input (A - B).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           request, sampled only when not busy (IDLE or DONE)
//   a, b, ci        operands and carry-in, captured on an accepted start
//   sub             (WIDE_ADD_SUB_EN only) 1 = subtract, ci ignored
//   busy            high while slices are in flight
//   done            one-cycle pulse when sum/co/overflow are valid
//   sum, co         registered result and unsigned carry-out
//   overflow        registered two's-complement overflow of the full add
//
// Latency: accept at edge t, slice i written at edge t+1+i, done high in the
// cycle after edge t+K. start during RUN is dropped, never queued.

// addern: N-bit combinational slice adder with carry and signed overflow.
module addern #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         overflow
);
  logic [N:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
  assign s    = full[N-1:0];
  assign co   = full[N];
  // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ cin = s.
  assign overflow = full[N] ^ (a[N-1] ^ b[N-1] ^ full[N-1]);
endmodule

module wide_add_seq #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           ci,
`ifdef WIDE_ADD_SUB_EN
  input  logic           sub,
`endif
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] sum,
  output logic           co,
  output logic           overflow
);
  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          carry;

  // Operand/carry values to capture on an accepted start.
  logic [W-1:0]  b_load;
  logic          c_load;

`ifdef WIDE_ADD_SUB_EN
  // Subtraction as A + ~B + 1; the external carry-in is ignored.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : ci;
`else
  assign b_load = b;
  assign c_load = ci;
`endif

  logic [N-1:0] sl_a;
  logic [N-1:0] sl_b;
  logic [N-1:0] sl_s;
  logic         sl_co;
  logic         sl_ovf;

  // Slice mux driven directly from the registered index.
  assign sl_a = opa[idx*N +: N];
  assign sl_b = opb[idx*N +: N];

  addern #(.N(N)) u_addern (
    .a        (sl_a),
    .b        (sl_b),
    .ci       (carry),
    .s        (sl_s),
    .co       (sl_co),
    .overflow (sl_ovf)
  );

  logic accept;
  logic last;

  assign accept = start && (state != RUN);
  assign last   = (idx == IW'(K - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      opa      <= '0;
      opb      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      co       <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (accept) begin
      // From IDLE or DONE (back-to-back); previous result stays visible.
      opa   <= a;
      opb   <= b_load;
      carry <= c_load;
      idx   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          sum[idx*N +: N] <= sl_s;
          carry           <= sl_co;
          if (last) begin
            co       <= sl_co;
            overflow <= sl_ovf;
            busy     <= 1'b0;
            done     <= 1'b1;
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed-vector bench for wide_add_seq at N=8, K=4 (W=32).
module tb_wide_add_seq;
  localparam int N = 8;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
`ifdef WIDE_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
  logic         overflow;

  int n_vec = 0;
  int n_err = 0;

  wide_add_seq #(.N(N), .K(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .ci       (ci),
`ifdef WIDE_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .co       (co),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Wait (sampling on negedges) until done is seen; returns the number of
  // rising edges crossed, or 99 if the bound expires.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!done) edges = 99;
  endtask

  // One operation: accept, check busy, latency and the registered result.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tci, input logic tsub,
                        input logic [W-1:0] es, input logic eco, input logic eovf);
    int edges;
    @(negedge clk);
    a = ta; b = tb_; ci = tci; start = 1'b1;
`ifdef WIDE_ADD_SUB_EN
    sub = tsub;
`else
    if (tsub) $display("note: %s requested sub without WIDE_ADD_SUB_EN", tag);
`endif
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; ci = 1'b1;  // inputs free after accept
    check({tag, ".busy"}, {63'd0, busy}, 64'd1);
    wait_done(edges);
    check({tag, ".lat"}, 64'(edges), 64'(K));
    check({tag, ".sum"}, {32'd0, sum}, {32'd0, es});
    check({tag, ".co"}, {63'd0, co}, {63'd0, eco});
    check({tag, ".ovf"}, {63'd0, overflow}, {63'd0, eovf});
    check({tag, ".busy_done"}, {63'd0, busy}, 64'd0);
    @(negedge clk);
    check({tag, ".pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int edges;
    int pulses;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    sub = 1'b0;
`endif
    // Reset/idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.sum", {32'd0, sum}, 64'd0);
    check("rst.co", {63'd0, co}, 64'd0);
    check("rst.ovf", {63'd0, overflow}, 64'd0);
    check("rst.busy", {63'd0, busy}, 64'd0);
    check("rst.done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("idle.nodone", 64'(pulses), 64'd0);

    // Carry ripple and signed-overflow corners.
    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run_op("cin", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Back-to-back with start held high; new operands presented during RUN
    // must not be taken until the DONE cycle.
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; ci = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'h0000_0001; b = 32'h0000_0002; ci = 1'b1;
    wait_done(edges);
    check("b2b.lat1", 64'(edges), 64'(K));
    check("b2b.sum1", {32'd0, sum}, 64'h2345_678A);
    check("b2b.co1", {63'd0, co}, 64'd0);
    edges = 0;
    @(posedge clk);
    edges++;
    @(negedge clk);
    start = 1'b0;
    check("b2b.reaccept", {62'd0, busy, done}, 64'd2);
    while (!done && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("b2b.lat2", 64'(edges), 64'(K + 1));
    check("b2b.sum2", {32'd0, sum}, 64'h0000_0004);
    check("b2b.co2", {63'd0, co}, 64'd0);

    // Reset in the middle of a run (idx=2).
    @(negedge clk);
    a = 32'h0101_0101; b = 32'h0202_0202; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.sum", {32'd0, sum}, 64'd0);
    check("midrst.flags", {60'd0, busy, done, co, overflow}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst.nodone", 64'(pulses), 64'd0);
    run_op("after_rst", 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, 32'h0303_0303, 1'b0, 1'b0);

`ifdef WIDE_ADD_SUB_EN
    run_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op("add_sub0", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_000D, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
